mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter for the single-port main memory shared by the instruction-fetch stage and the MEM stage of the 16-bit five-stage core. It grants one access at a time, drives the RAM port, routes read data back to the owning requester with a fixed latency, and exposes wait signals that the pipeline controller uses to derive its `en_pc` and `en_*`/`flush_*` pipeline-register controls. It sits between the IF and MEM stages and the main memory. It is controlled by the pipeline; it does not control it.

## Interface
- `LAT`, 1: RAM read latency in cycles. Legal range 1..4.
- `STARVE_MAX`, 3: number of consecutive MEM grants allowed while a fetch waits. Legal range 1..15.
- `clk`, input, 1: clock. Everything is rising-edge.
- `reset`, input, 1: reset. Synchronous, active-high.
- `if_req`, input, 1: fetch request. Held until granted.
- `if_adr`, input, 16: fetch address.
- `if_flush`, input, 1: jump taken. Squashes an in-flight fetch result.
- `mem_req`, input, 1: data request. Held until granted.
- `mem_we`, input, 1: 1 = store, 0 = load.
- `mem_adr`, input, 16: data address.
- `mem_wdat`, input, 16: store data.
- `ram_adr`, output, 16: RAM address.
- `ram_we`, output, 1: RAM write strobe.
- `ram_wdat`, output, 16: RAM write data.
- `ram_rdat`, input, 16: RAM read data. Valid `LAT` cycles after the address is presented.
- `if_grant`, output, 1: fetch issued this cycle. Combinational.
- `mem_grant`, output, 1: data access issued this cycle. Combinational.
- `if_valid`, output, 1: one-cycle pulse; `if_rdat` is valid.
- `if_rdat`, output, 16: fetched instruction.
- `mem_valid`, output, 1: one-cycle pulse; load data is valid or a store is acknowledged.
- `mem_rdat`, output, 16: load data. 0 on a store acknowledge.
- `if_wait`, output, 1: `if_req & ~if_grant`.
- `mem_wait`, output, 1: `mem_req & ~mem_grant`.

## Operation
- **State.**
  - `busy_cnt` (3 bits): remaining port occupancy.
  - `owner`: IF or MEM.
  - `is_wr`
  - `squash`
  - `starve_cnt` (4 bits)
- **Issue window.** The port can issue when `busy_cnt==0`, or when `busy_cnt==1` (the completion cycle of the current access).
- **Arbitration in an issue window.**
  - Only `mem_req` is set: MEM wins.
  - Only `if_req` is set: IF wins.
  - Both are set: MEM wins, except in the `ARB_STARVE_GUARD_EN` case below.
- **Grant.** Exactly one grant, combinational in the issue cycle. `ram_adr`, `ram_we` and `ram_wdat` come from the winner in that same cycle.
  - `ram_we` = `mem_grant & mem_we`.
  - With no grant, `ram_we` = 0 and `ram_adr` = `if_adr`.
- **Read issue.** Load `busy_cnt` with `LAT`, record `owner`, set `is_wr`=0.
- **Write issue.** Load `busy_cnt` with 1, set `is_wr`=1.
- **Countdown.** `busy_cnt` decrements every cycle while non-zero, unless it is reloaded by a new issue.
- **Completion cycle** (`busy_cnt==1`): pulse the owner's `*_valid`.
  - Reads: `*_rdat` = `ram_rdat`.
  - Writes: `mem_valid`=1 and `mem_rdat`=0.
- **Handshake.**
  - A requester must hold address, data and `we` stable while `*_req` is high and grant is low.
  - After a grant, the requester drops `*_req` or presents its next request in the following cycle.
  - At most one access is outstanding.
- **Flush.**
  - If `if_flush` is asserted while an IF read is outstanding, or in its issue cycle, set `squash`. A squashed completion produces no `if_valid`, but the port stays occupied until completion. `squash` clears at completion.
  - `if_flush` in the same cycle as an IF completion suppresses that `if_valid`.
  - `if_flush` never affects MEM transactions.
- **Simultaneous events.** A completion and a new grant in the same cycle are legal. The new owner is registered and the old `*_valid` is emitted from the old owner.

## Timing
- **Reset values.** All registered state is 0. On the cycle after reset, every output is 0 except the combinational outputs. `ram_adr` = `if_adr`.
- **Reset mid-operation.** Any outstanding access is abandoned and no `*_valid` is produced for it. Grants are forced to 0 during the reset cycle.
- **Read latency.** A grant at cycle T gives `*_valid` at T+`LAT`.
- **Store acknowledge.** A store granted at T gives `mem_valid` at T+1.
- **Throughput.**
  - With `LAT`=1, reads can issue back-to-back every cycle.
  - In general, one read per `LAT` cycles and one write per cycle.
- **Starvation accounting.** `starve_cnt` increments on every MEM grant made while `if_req` is high. It saturates at `STARVE_MAX` and clears on an IF grant or whenever `if_req` is low.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: when both request and `starve_cnt==STARVE_MAX`, IF wins.
- `ARB_STARVE_GUARD_EN` undefined: strict MEM priority, and the `starve_cnt` logic is not built.

## Test plan
- **Single fetch.** `LAT`=2, `if_req` with `if_adr`=0x0010 at T, RAM returns 0xA5A5 at T+2 -> `if_grant`@T, `if_valid`@T+2 only, `if_rdat`=0xA5A5.
- **Contention.** `if_req` and `mem_req` (load 0x0200) both at T, `LAT`=1 -> `mem_grant`@T, `if_wait`@T, `if_grant`@T+1, `mem_valid`@T+1, `if_valid`@T+2.
- **Store then load.** Store 0x1234 to 0x0300 at T, then load 0x0300 at T+1 -> `ram_we`=1 only at T, `mem_valid`@T+1 with `mem_rdat`=0, load data 0x1234 at T+1+`LAT`.
- **Flush.** `if_flush` at T+1 after a fetch granted at T (`LAT`=3) -> no `if_valid` at T+3, the next fetch can be granted at T+3, and its data is returned normally.
- **Starvation guard.** `STARVE_MAX`=3, `LAT`=1, `mem_req` and `if_req` held high:
  - With `ARB_STARVE_GUARD_EN` defined -> three `mem_grant` cycles, then `if_grant` on the fourth.
  - With `ARB_STARVE_GUARD_EN` undefined -> `if_grant` never asserts while `mem_req` is high.
- **Reset mid-read.** `reset` at T+1 after a read granted at T (`LAT`=3) -> no `*_valid` at T+3, `busy_cnt`=0, and a request at T+2 is granted immediately.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port main memory between the instruction-fetch stage (IF)
// and the MEM stage of the 16-bit five-stage core. One access is outstanding
// at a time. The winner drives the RAM port combinationally in its issue
// cycle, and read data is routed back to the owner after LAT cycles. The
// wait outputs let the pipeline controller stall; this block never stalls
// the pipeline itself.
//
// Parameters
//   LAT         RAM read latency in cycles (1..4)
//   STARVE_MAX  consecutive MEM grants tolerated while a fetch waits (1..15)
//
// Build option
//   ARB_STARVE_GUARD_EN  when defined, IF wins a collision once starve_cnt
//                        reaches STARVE_MAX. When undefined, MEM has strict
//                        priority and no starvation counter is built.
//
// Ports
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   if_req/if_adr/if_flush       fetch request, address, jump-taken squash
//   mem_req/mem_we/mem_adr/
//   mem_wdat                     load/store request
//   ram_adr/ram_we/ram_wdat      RAM port, driven by the current winner
//   ram_rdat                     RAM read data, valid LAT cycles after address
//   if_grant/mem_grant           combinational issue strobes
//   if_valid/if_rdat             fetched instruction, one-cycle pulse
//   mem_valid/mem_rdat           load data or store acknowledge (data 0)
//   if_wait/mem_wait             request pending but not granted this cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned LAT        = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [15:0] if_adr,
    input  logic        if_flush,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_adr,
    input  logic [15:0] mem_wdat,

    output logic [15:0] ram_adr,
    output logic        ram_we,
    output logic [15:0] ram_wdat,
    input  logic [15:0] ram_rdat,

    output logic        if_grant,
    output logic        mem_grant,
    output logic        if_valid,
    output logic [15:0] if_rdat,
    output logic        mem_valid,
    output logic [15:0] mem_rdat,
    output logic        if_wait,
    output logic        mem_wait
);

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Port occupancy of the single outstanding access.
    logic [2:0] busy_cnt, busy_cnt_n;
    owner_t     owner,    owner_n;
    logic       is_wr,    is_wr_n;
    logic       squash,   squash_n;

    logic       done;      // completion cycle of the outstanding access
    logic       issue_ok;  // port may accept a new access this cycle
    logic       if_first;  // starvation guard overrides MEM priority

    assign done     = (busy_cnt == 3'd1);
    // The completion cycle doubles as an issue slot, so back-to-back
    // accesses lose no cycle. Grants are held off during reset.
    assign issue_ok = ~reset & (busy_cnt <= 3'd1);

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt, starve_cnt_n;

    assign if_first = (starve_cnt == 4'(STARVE_MAX));

    // Counts MEM grants that overtook a waiting fetch; any fetch grant or a
    // cycle without a fetch request starts the count over.
    always_comb begin
        starve_cnt_n = starve_cnt;
        if (!if_req || if_grant) begin
            starve_cnt_n = '0;
        end else if (mem_grant && (starve_cnt != 4'(STARVE_MAX))) begin
            starve_cnt_n = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_n;
        end
    end
`else
    // Strict MEM priority: STARVE_MAX has no effect in this build.
    logic [3:0] unused_starve_max;
    assign unused_starve_max = 4'(STARVE_MAX);
    assign if_first          = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Arbitration and RAM port
    // ---------------------------------------------------------------------
    assign mem_grant = issue_ok & mem_req & ~(if_req & if_first);
    assign if_grant  = issue_ok & if_req & ~mem_grant;

    // The fetch address is parked on the port whenever MEM is not issuing.
    assign ram_adr  = mem_grant ? mem_adr : if_adr;
    assign ram_we   = mem_grant & mem_we;
    assign ram_wdat = mem_grant ? mem_wdat : '0;

    assign if_wait  = if_req  & ~if_grant;
    assign mem_wait = mem_req & ~mem_grant;

    // ---------------------------------------------------------------------
    // Completion: the old owner is reported even if a new access is being
    // granted in the same cycle. A flush in the completion cycle itself
    // also kills the fetch result.
    // ---------------------------------------------------------------------
    assign if_valid  = ~reset & done & (owner == OWN_IF) & ~is_wr & ~squash & ~if_flush;
    assign mem_valid = ~reset & done & (owner == OWN_MEM);
    assign if_rdat   = if_valid ? ram_rdat : '0;
    assign mem_rdat  = (mem_valid & ~is_wr) ? ram_rdat : '0;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned; a missing default infers a latch.
    always_comb begin
        busy_cnt_n = busy_cnt;
        owner_n    = owner;
        is_wr_n    = is_wr;
        squash_n   = squash;

        if (if_grant || mem_grant) begin
            owner_n    = if_grant ? OWN_IF : OWN_MEM;
            is_wr_n    = ram_we;
            // Stores are acknowledged on the next cycle; reads wait LAT.
            busy_cnt_n = ram_we ? 3'd1 : 3'(LAT);
            // A flush in the issue cycle already kills the new fetch.
            squash_n   = if_grant & if_flush;
        end else if (busy_cnt != 3'd0) begin
            busy_cnt_n = busy_cnt - 3'd1;
            if (done) begin
                squash_n = 1'b0;
            end else if ((owner == OWN_IF) && !is_wr && if_flush) begin
                // The fetch keeps the port until its data returns; only the
                // result is dropped.
                squash_n = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= '0;
            owner    <= OWN_IF;
            is_wr    <= 1'b0;
            squash   <= 1'b0;
        end else begin
            busy_cnt <= busy_cnt_n;
            owner    <= owner_n;
            is_wr    <= is_wr_n;
            squash   <= squash_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Directed scenarios cover reset,
// a single fetch, contention, store-then-load, flush, starvation and reset
// in the middle of a read. A randomized phase drives both requesters with a
// legal hold-until-granted handshake and compares every cycle against a
// transaction-level model that tracks the outstanding access by its
// completion cycle number.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT        = 3;
    localparam int STARVE_MAX = 3;
    localparam int N_RANDOM   = 3000;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [15:0] if_adr;
    logic        if_flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [15:0] mem_wdat;
    logic [15:0] ram_adr;
    logic        ram_we;
    logic [15:0] ram_wdat;
    logic [15:0] ram_rdat;
    logic        if_grant;
    logic        mem_grant;
    logic        if_valid;
    logic [15:0] if_rdat;
    logic        mem_valid;
    logic [15:0] mem_rdat;
    logic        if_wait;
    logic        mem_wait;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter #(
        .LAT        (LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_adr    (if_adr),
        .if_flush  (if_flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdat  (mem_wdat),
        .ram_adr   (ram_adr),
        .ram_we    (ram_we),
        .ram_wdat  (ram_wdat),
        .ram_rdat  (ram_rdat),
        .if_grant  (if_grant),
        .mem_grant (mem_grant),
        .if_valid  (if_valid),
        .if_rdat   (if_rdat),
        .mem_valid (mem_valid),
        .mem_rdat  (mem_rdat),
        .if_wait   (if_wait),
        .mem_wait  (mem_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // RAM: read-first, LAT-cycle read pipeline, unwritten words have a
    // fixed address-derived content.
    // ---------------------------------------------------------------------
    logic [15:0] ram_arr [0:65535];
    bit          ram_wr  [0:65535];
    logic [15:0] rd_pipe [0:LAT-1];

    function automatic logic [15:0] ram_init(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= ram_wr[ram_adr] ? ram_arr[ram_adr] : ram_init(ram_adr);
        if (ram_we) begin
            ram_arr[ram_adr] <= ram_wdat;
            ram_wr[ram_adr]  <= 1'b1;
        end
    end

    assign ram_rdat = rd_pipe[LAT-1];

    // Reference memory image for the randomized phase.
    logic [15:0] ref_val [0:65535];
    bit          ref_wr  [0:65535];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req   = 1'b0;
        if_flush = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
    endtask

    task automatic settle();
        idle_inputs();
        for (int k = 0; k < LAT + 1; k++) cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; if_adr = 16'h0ABC;
        mem_req = 1'b1; mem_we = 1'b1; mem_adr = 16'h0DEF; mem_wdat = 16'hFFFF;
        cycle();
        @(negedge clk);
        n_cmp++;
        if ({if_grant, mem_grant, ram_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_grants: got if_grant/mem_grant/ram_we=%b, expected 000",
                     {if_grant, mem_grant, ram_we});
        end
        cycle();
        reset = 1'b0; idle_inputs(); if_adr = 16'h1111;
        @(negedge clk);
        n_cmp++;
        if ({if_grant, mem_grant, if_valid, mem_valid, if_wait, mem_wait, ram_we} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b, expected 0000000",
                     {if_grant, mem_grant, if_valid, mem_valid, if_wait, mem_wait, ram_we});
        end
        n_cmp++;
        if (ram_adr !== 16'h1111) begin
            n_fail++;
            $display("FAIL reset_ram_adr: got %h, expected 1111", ram_adr);
        end
        n_cmp++;
        if ({if_rdat, mem_rdat} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdat: got if_rdat=%h mem_rdat=%h, expected 0/0", if_rdat, mem_rdat);
        end
        cycle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_single_fetch();
        if_req = 1'b1; if_adr = 16'h0010;
        @(negedge clk);
        n_cmp++;
        if (if_grant !== 1'b1 || ram_adr !== 16'h0010 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_grant: got grant=%b adr=%h valid=%b, expected 1/0010/0",
                     if_grant, ram_adr, if_valid);
        end
        cycle();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if (if_valid !== 1'(k == LAT) || mem_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_valid@+%0d: got if_valid=%b mem_valid=%b, expected %b/0",
                         k, if_valid, mem_valid, 1'(k == LAT));
            end
            if (k == LAT) begin
                n_cmp++;
                if (if_rdat !== ram_init(16'h0010)) begin
                    n_fail++;
                    $display("FAIL fetch_rdat: got %h, expected %h", if_rdat, ram_init(16'h0010));
                end
            end
            cycle();
        end
        settle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_contention();
        if_req = 1'b1; if_adr = 16'h0020;
        mem_req = 1'b1; mem_we = 1'b0; mem_adr = 16'h0200;
        @(negedge clk);
        n_cmp++;
        if ({mem_grant, if_grant, if_wait, mem_wait} !== 4'b1010 || ram_adr !== 16'h0200) begin
            n_fail++;
            $display("FAIL contention_issue: got mg/ig/iw/mw=%b adr=%h, expected 1010/0200",
                     {mem_grant, if_grant, if_wait, mem_wait}, ram_adr);
        end
        cycle();
        mem_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({if_grant, if_wait, mem_valid} !== {1'(k == LAT), 1'(k != LAT), 1'(k == LAT)}) begin
                n_fail++;
                $display("FAIL contention_wait@+%0d: got ig/iw/mv=%b, expected %b",
                         k, {if_grant, if_wait, mem_valid}, {1'(k == LAT), 1'(k != LAT), 1'(k == LAT)});
            end
            if (k == LAT) begin
                n_cmp++;
                if (mem_rdat !== ram_init(16'h0200) || ram_adr !== 16'h0020) begin
                    n_fail++;
                    $display("FAIL contention_load: got rdat=%h adr=%h, expected %h/0020",
                             mem_rdat, ram_adr, ram_init(16'h0200));
                end
            end
            cycle();
        end
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if (if_valid !== 1'(k == LAT) || mem_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_fetch@+%0d: got if_valid=%b mem_valid=%b, expected %b/0",
                         k, if_valid, mem_valid, 1'(k == LAT));
            end
            if (k == LAT) begin
                n_cmp++;
                if (if_rdat !== ram_init(16'h0020)) begin
                    n_fail++;
                    $display("FAIL contention_fetch_rdat: got %h, expected %h", if_rdat, ram_init(16'h0020));
                end
            end
            cycle();
        end
        settle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_store_load();
        mem_req = 1'b1; mem_we = 1'b1; mem_adr = 16'h0300; mem_wdat = 16'h1234;
        @(negedge clk);
        n_cmp++;
        if ({mem_grant, ram_we} !== 2'b11 || ram_adr !== 16'h0300 || ram_wdat !== 16'h1234) begin
            n_fail++;
            $display("FAIL store_issue: got mg/we=%b adr=%h wdat=%h, expected 11/0300/1234",
                     {mem_grant, ram_we}, ram_adr, ram_wdat);
        end
        cycle();
        mem_we = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_grant, ram_we, mem_valid} !== 3'b101 || mem_rdat !== 16'h0) begin
            n_fail++;
            $display("FAIL store_ack: got mg/we/mv=%b rdat=%h, expected 101/0000",
                     {mem_grant, ram_we, mem_valid}, mem_rdat);
        end
        cycle();
        mem_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_valid !== 1'(k == LAT) || ram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL load_valid@+%0d: got mem_valid=%b ram_we=%b, expected %b/0",
                         k, mem_valid, ram_we, 1'(k == LAT));
            end
            if (k == LAT) begin
                n_cmp++;
                if (mem_rdat !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL load_rdat: got %h, expected 1234", mem_rdat);
                end
            end
            cycle();
        end
        settle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_flush();
        if_req = 1'b1; if_adr = 16'h0040;
        @(negedge clk);
        n_cmp++;
        if (if_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_first_grant: got %b, expected 1", if_grant);
        end
        cycle();
        if_req = 1'b0; if_flush = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if (if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_quiet@+%0d: got if_valid=%b, expected 0", k, if_valid);
            end
            cycle();
            if_flush = 1'b0;
        end
        if_req = 1'b1; if_adr = 16'h0044;
        @(negedge clk);
        n_cmp++;
        if ({if_valid, if_grant} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_squashed_completion: got valid/grant=%b, expected 01", {if_valid, if_grant});
        end
        cycle();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if (if_valid !== 1'(k == LAT)) begin
                n_fail++;
                $display("FAIL flush_refetch@+%0d: got if_valid=%b, expected %b", k, if_valid, 1'(k == LAT));
            end
            if (k == LAT) begin
                n_cmp++;
                if (if_rdat !== ram_init(16'h0044)) begin
                    n_fail++;
                    $display("FAIL flush_refetch_rdat: got %h, expected %h", if_rdat, ram_init(16'h0044));
                end
            end
            cycle();
        end
        settle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_starvation();
        if_req = 1'b1; if_adr = 16'h0050;
`ifdef ARB_STARVE_GUARD_EN
        for (int j = 0; j <= STARVE_MAX; j++) begin
            mem_req = 1'b1; mem_we = 1'b1; mem_adr = 16'h0400 + 16'(j); mem_wdat = 16'(j);
            @(negedge clk);
            n_cmp++;
            if ({if_grant, mem_grant} !== {1'(j == STARVE_MAX), 1'(j != STARVE_MAX)}) begin
                n_fail++;
                $display("FAIL starve_guard@%0d: got ig/mg=%b, expected %b",
                         j, {if_grant, mem_grant}, {1'(j == STARVE_MAX), 1'(j != STARVE_MAX)});
            end
            cycle();
        end
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_grant !== 1'(k == LAT)) begin
                n_fail++;
                $display("FAIL starve_mem_resume@+%0d: got mem_grant=%b, expected %b",
                         k, mem_grant, 1'(k == LAT));
            end
            cycle();
        end
`else
        for (int j = 0; j < 8; j++) begin
            mem_req = 1'b1; mem_we = 1'b1; mem_adr = 16'h0400 + 16'(j); mem_wdat = 16'(j);
            @(negedge clk);
            n_cmp++;
            if ({if_grant, mem_grant} !== 2'b01) begin
                n_fail++;
                $display("FAIL strict_priority@%0d: got ig/mg=%b, expected 01", j, {if_grant, mem_grant});
            end
            cycle();
        end
        mem_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL strict_release: got if_grant=%b, expected 1", if_grant);
        end
        cycle();
`endif
        settle();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid_read();
        if_req = 1'b1; if_adr = 16'h0050;
        @(negedge clk);
        n_cmp++;
        if (if_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_grant: got %b, expected 1", if_grant);
        end
        cycle();
        if_req = 1'b0; reset = 1'b1;
        mem_req = 1'b1; mem_we = 1'b0; mem_adr = 16'h0060;
        @(negedge clk);
        n_cmp++;
        if ({if_grant, mem_grant, if_valid, mem_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_forced: got ig/mg/iv/mv=%b, expected 0000",
                     {if_grant, mem_grant, if_valid, mem_valid});
        end
        cycle();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_immediate: got mem_grant=%b, expected 1", mem_grant);
        end
        cycle();
        mem_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({if_valid, mem_valid} !== {1'b0, 1'(k == LAT)}) begin
                n_fail++;
                $display("FAIL rst_mid_after@+%0d: got iv/mv=%b, expected %b",
                         k, {if_valid, mem_valid}, {1'b0, 1'(k == LAT)});
            end
            if (k == LAT) begin
                n_cmp++;
                if (mem_rdat !== ram_init(16'h0060)) begin
                    n_fail++;
                    $display("FAIL rst_mid_rdat: got %h, expected %h", mem_rdat, ram_init(16'h0060));
                end
            end
            cycle();
        end
        settle();
    endtask

    // ---------------------------------------------------------------------
    // Randomized traffic against a transaction-level model.
    // ---------------------------------------------------------------------
    task automatic test_random(input int n);
        logic        pif_g, pmem_g;
        logic        m_busy, m_own_if, m_wr, m_squash;
        int          m_done, m_starve;
        logic [15:0] m_data;
        logic        completing, can_issue, if_first;
        logic        e_ig, e_mg, e_iv, e_mv, e_we;
        logic [15:0] e_adr, e_mrd;

        idle_inputs(); reset = 1'b1;
        cycle();
        reset = 1'b0;
        pif_g = 1'b0; pmem_g = 1'b0;
        m_busy = 1'b0; m_own_if = 1'b0; m_wr = 1'b0; m_squash = 1'b0;
        m_done = 0; m_starve = 0; m_data = '0;

        for (int i = 0; i < n; i++) begin
            if (!(if_req && !pif_g)) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_adr = 16'h8000 | 16'($urandom_range(0, 63));
            end
            if (!(mem_req && !pmem_g)) begin
                mem_req  = ($urandom_range(0, 2) != 0);
                mem_we   = ($urandom_range(0, 2) == 0);
                mem_adr  = 16'h8000 | 16'($urandom_range(0, 63));
                mem_wdat = 16'($urandom);
            end
            if_flush = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 199) == 0);
            @(negedge clk);

            completing = m_busy && (i == m_done);
            can_issue  = !reset && (!m_busy || completing);
            if_first   = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            if_first   = (m_starve == STARVE_MAX);
`endif
            e_mg  = can_issue && mem_req && !(if_req && if_first);
            e_ig  = can_issue && if_req && !e_mg;
            e_we  = e_mg && mem_we;
            e_adr = e_mg ? mem_adr : if_adr;
            e_iv  = !reset && completing && m_own_if && !m_squash && !if_flush;
            e_mv  = !reset && completing && !m_own_if;
            e_mrd = m_wr ? 16'h0 : m_data;

            n_cmp++;
            if ({if_grant, mem_grant, if_wait, mem_wait, ram_we, if_valid, mem_valid} !==
                {e_ig, e_mg, if_req & ~e_ig, mem_req & ~e_mg, e_we, e_iv, e_mv}) begin
                n_fail++;
                $display("FAIL rand_ctl@%0d: got ig/mg/iw/mw/we/iv/mv=%b, expected %b", i,
                         {if_grant, mem_grant, if_wait, mem_wait, ram_we, if_valid, mem_valid},
                         {e_ig, e_mg, if_req & ~e_ig, mem_req & ~e_mg, e_we, e_iv, e_mv});
            end
            n_cmp++;
            if (ram_adr !== e_adr) begin
                n_fail++;
                $display("FAIL rand_ram_adr@%0d: got %h, expected %h", i, ram_adr, e_adr);
            end
            if (e_we) begin
                n_cmp++;
                if (ram_wdat !== mem_wdat) begin
                    n_fail++;
                    $display("FAIL rand_ram_wdat@%0d: got %h, expected %h", i, ram_wdat, mem_wdat);
                end
            end
            if (e_iv) begin
                n_cmp++;
                if (if_rdat !== m_data) begin
                    n_fail++;
                    $display("FAIL rand_if_rdat@%0d: got %h, expected %h", i, if_rdat, m_data);
                end
            end
            if (e_mv) begin
                n_cmp++;
                if (mem_rdat !== e_mrd) begin
                    n_fail++;
                    $display("FAIL rand_mem_rdat@%0d: got %h, expected %h", i, mem_rdat, e_mrd);
                end
            end

            // Advance the model to the next cycle.
            if (reset) begin
                m_busy   = 1'b0;
                m_starve = 0;
            end else begin
                if (completing) m_busy = 1'b0;
                else if (m_busy && m_own_if && !m_wr && if_flush) m_squash = 1'b1;
                if (e_ig || e_mg) begin
                    m_busy   = 1'b1;
                    m_own_if = e_ig;
                    m_wr     = e_we;
                    m_done   = i + (e_we ? 1 : LAT);
                    m_squash = e_ig && if_flush;
                    m_data   = ref_wr[e_adr] ? ref_val[e_adr] : ram_init(e_adr);
                    if (e_we) begin
                        ref_wr[e_adr]  = 1'b1;
                        ref_val[e_adr] = mem_wdat;
                    end
                end
                if (!if_req || e_ig) m_starve = 0;
                else if (e_mg && m_starve < STARVE_MAX) m_starve++;
            end
            pif_g  = if_grant;
            pmem_g = mem_grant;
            cycle();
        end
        reset = 1'b0;
        settle();
    endtask

    initial begin
        reset    = 1'b1;
        if_req   = 1'b0;
        if_adr   = 16'h0000;
        if_flush = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_adr  = 16'h0000;
        mem_wdat = 16'h0000;

        test_reset();
        test_single_fetch();
        test_contention();
        test_store_load();
        test_flush();
        test_starvation();
        test_reset_mid_read();
        test_random(N_RANDOM);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
